// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side signals for mem_arbiter.
// slave is the arbiter's view; master is the view of the requesters and the memory.
interface mem_arbiter_if #(
    parameter int W = 16
);
    logic         d_req;
    logic         d_wr;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic         d_done;
    logic [W-1:0] d_rdata;
    logic         d_stall;
    logic         i_req;
    logic [W-1:0] i_addr;
    logic         i_done;
    logic [W-1:0] i_rdata;
    logic         i_stall;
    logic         mem_en;
    logic         mem_wr;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_done;

    modport slave (
        input  d_req, d_wr, d_addr, d_wdata, i_req, i_addr, mem_rdata, mem_done,
        output d_done, d_rdata, d_stall, i_done, i_rdata, i_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output d_req, d_wr, d_addr, d_wdata, i_req, i_addr, mem_rdata, mem_done,
        input  d_done, d_rdata, d_stall, i_done, i_rdata, i_stall,
               mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a data side and an instruction-fetch side.
// Define MEM_ARB_RR_EN to alternate owners on contention; otherwise the data side always wins.
module mem_arbiter #(
    parameter int W = 16
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t       r_state;
    state_t       w_next;
    owner_t       r_owner;
    owner_t       w_grant;
    logic [W-1:0] r_addr;
    logic [W-1:0] r_wdata;
    logic         r_wr;
    logic         w_any;
    logic         w_busy;
    logic         w_fin;
    logic         w_d_fin;
    logic         w_i_fin;

`ifdef MEM_ARB_RR_EN
    owner_t r_last;
    assign w_grant = (bus.d_req && bus.i_req) ? (r_last == OWN_D ? OWN_I : OWN_D)
                                              : (bus.d_req ? OWN_D : OWN_I);
`else
    assign w_grant = bus.d_req ? OWN_D : OWN_I;
`endif

    assign w_any  = bus.d_req | bus.i_req;
    assign w_busy = r_state != IDLE;
    // rst masks completion so an abandoned access never pulses done
    assign w_fin   = w_busy && bus.mem_done && !rst;
    assign w_d_fin = w_fin && r_owner == OWN_D;
    assign w_i_fin = w_fin && r_owner == OWN_I;

    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (w_any ? ISSUE : IDLE) : (w_fin ? IDLE : WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            r_last  <= OWN_I;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_owner <= w_grant;
                r_addr  <= w_grant == OWN_D ? bus.d_addr : bus.i_addr;
                r_wr    <= w_grant == OWN_D && bus.d_wr;
                r_wdata <= w_grant == OWN_D ? bus.d_wdata : '0;
            end
`ifdef MEM_ARB_RR_EN
            if (w_fin) r_last <= r_owner;
`endif
        end
    end

    assign bus.mem_en    = r_state == ISSUE;
    assign bus.mem_wr    = w_busy && r_wr;
    assign bus.mem_addr  = w_busy ? r_addr : '0;
    assign bus.mem_wdata = w_busy ? r_wdata : '0;
    assign bus.d_done    = w_d_fin;
    assign bus.i_done    = w_i_fin;
    assign bus.d_rdata   = w_d_fin ? bus.mem_rdata : '0;
    assign bus.i_rdata   = w_i_fin ? bus.mem_rdata : '0;
    assign bus.d_stall   = bus.d_req && !w_d_fin;
    assign bus.i_stall   = bus.i_req && !w_i_fin;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level model checked every cycle.
// Honours MEM_ARB_RR_EN the same way as the design.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;

    mem_arbiter_if #(.W(16)) bus ();
    mem_arbiter #(.W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: one outstanding transaction record
    bit          m_valid = 0;
    bit          m_busy = 0;
    bit          m_first = 0;
    bit          m_own_d = 0;
    bit          m_last_d = 0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    bit          m_wr = 0;

    always @(posedge clk) begin
        bit pick_d;
        if (rst) begin
            m_valid  = 1;
            m_busy   = 0;
            m_last_d = 0;
        end else if (m_busy) begin
            if (bus.mem_done) begin
                m_busy   = 0;
                m_last_d = m_own_d;
            end else m_first = 0;
        end else if (bus.d_req || bus.i_req) begin
`ifdef MEM_ARB_RR_EN
            pick_d = bus.d_req && !(bus.i_req && m_last_d);
`else
            pick_d = bus.d_req;
`endif
            m_own_d = pick_d;
            m_busy  = 1;
            m_first = 1;
            m_addr  = pick_d ? bus.d_addr : bus.i_addr;
            m_wr    = pick_d && bus.d_wr;
            m_wdata = pick_d ? bus.d_wdata : 16'h0;
        end
    end

    always @(negedge clk) begin
        bit fin, dd, id;
        if (m_valid) begin
            fin = !rst && m_busy && bus.mem_done;
            dd  = fin && m_own_d;
            id  = fin && !m_own_d;
            chk("mem_en", 32'(bus.mem_en), 32'(m_busy && m_first));
            chk("mem_wr", 32'(bus.mem_wr), 32'(m_busy && m_wr));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_busy ? m_addr : 16'h0));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_busy ? m_wdata : 16'h0));
            chk("d_done", 32'(bus.d_done), 32'(dd));
            chk("i_done", 32'(bus.i_done), 32'(id));
            chk("d_rdata", 32'(bus.d_rdata), 32'(dd ? bus.mem_rdata : 16'h0));
            chk("i_rdata", 32'(bus.i_rdata), 32'(id ? bus.mem_rdata : 16'h0));
            chk("d_stall", 32'(bus.d_stall), 32'(bus.d_req && !dd));
            chk("i_stall", 32'(bus.i_stall), 32'(bus.i_req && !id));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] second_addr;
        rst = 1; bus.d_req = 1; bus.i_req = 1; bus.d_wr = 0;
        bus.d_addr = 16'h0; bus.d_wdata = 16'h0; bus.i_addr = 16'h0;
        bus.mem_done = 0; bus.mem_rdata = 16'h0;
        step(); step();
        mid();
        chk("rst mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst dones", {bus.d_done, bus.i_done}, 32'h0);
        chk("rst stalls", {bus.d_stall, bus.i_stall}, 32'h3);
        chk("rst mem_addr", 32'(bus.mem_addr), 32'h0);
        step(); rst = 0; bus.d_req = 0; bus.i_req = 0;
        step();

        // single fetch, memory answers one cycle after mem_en
        bus.i_req = 1; bus.i_addr = 16'h0040;
        step();
        mid();
        chk("rd mem_en", 32'(bus.mem_en), 32'h1);
        chk("rd mem_addr", 32'(bus.mem_addr), 32'h0040);
        step(); bus.mem_done = 1; bus.mem_rdata = 16'hBEEF;
        mid();
        chk("rd i_done", 32'(bus.i_done), 32'h1);
        chk("rd i_rdata", 32'(bus.i_rdata), 32'hBEEF);
        chk("rd i_stall", 32'(bus.i_stall), 32'h0);
        step(); bus.i_req = 0; bus.mem_done = 0; bus.mem_rdata = 16'h0;
        step();

        // minimum latency: memory done while still in ISSUE
        bus.d_req = 1; bus.d_addr = 16'h0022;
        step(); bus.mem_done = 1; bus.mem_rdata = 16'h5A5A;
        mid();
        chk("fast d_done", 32'(bus.d_done), 32'h1);
        chk("fast d_rdata", 32'(bus.d_rdata), 32'h5A5A);
        step(); bus.d_req = 0; bus.mem_done = 0; bus.mem_rdata = 16'h0;
        step();

        // contention: data first, then both re-request
        bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h1000; bus.d_wdata = 16'h1234;
        bus.i_req = 1; bus.i_addr = 16'h0002;
        step();
        mid();
        chk("ct1 mem_addr", 32'(bus.mem_addr), 32'h1000);
        chk("ct1 mem_wr", 32'(bus.mem_wr), 32'h1);
        chk("ct1 mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        bus.d_addr = 16'hFFFF; bus.d_wdata = 16'hAAAA;
        step(); bus.mem_done = 1; bus.mem_rdata = 16'h7777;
        mid();
        chk("ct1 latched addr", 32'(bus.mem_addr), 32'h1000);
        chk("ct1 done pair", {bus.d_done, bus.i_done}, 32'h2);
        step(); bus.mem_done = 0; bus.d_addr = 16'h1000; bus.d_wdata = 16'h1234;
        step();
`ifdef MEM_ARB_RR_EN
        second_addr = 16'h0002;
`else
        second_addr = 16'h1000;
`endif
        mid();
        chk("ct2 mem_addr", 32'(bus.mem_addr), 32'(second_addr));
        bus.mem_done = 1;
        #1;
        chk("ct2 owner done", {bus.d_done, bus.i_done}, (second_addr == 16'h1000) ? 32'h2 : 32'h1);
        step(); bus.mem_done = 0; bus.d_req = 0; bus.i_req = 0; bus.d_wr = 0;
        step();

        // long latency fetch
        bus.i_req = 1; bus.i_addr = 16'h0ABC;
        step();
        mid();
        chk("ll mem_en first", 32'(bus.mem_en), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            mid();
            chk("ll mem_en held low", 32'(bus.mem_en), 32'h0);
            chk("ll mem_addr", 32'(bus.mem_addr), 32'h0ABC);
            chk("ll i_stall", 32'(bus.i_stall), 32'h1);
        end
        step(); bus.mem_done = 1; bus.mem_rdata = 16'h1111; bus.i_req = 0;
        mid();
        chk("ll i_done after req drop", 32'(bus.i_done), 32'h1);
        step(); bus.mem_done = 0; bus.mem_rdata = 16'h0;
        step();

        // reset while waiting on memory
        bus.d_req = 1; bus.d_addr = 16'h0300;
        step(); step();
        rst = 1;
        step(); rst = 0; bus.d_req = 0; bus.mem_done = 1; bus.mem_rdata = 16'hDEAD;
        mid();
        chk("rstw d_done", 32'(bus.d_done), 32'h0);
        chk("rstw mem_en", 32'(bus.mem_en), 32'h0);
        chk("rstw mem_addr", 32'(bus.mem_addr), 32'h0);
        step(); bus.mem_done = 0;
        mid();
        chk("rstw stays idle", 32'(bus.mem_en), 32'h0);

        // stray mem_done in IDLE
        step(); bus.mem_done = 1; bus.mem_rdata = 16'h4321;
        mid();
        chk("stray dones", {bus.d_done, bus.i_done}, 32'h0);
        step(); bus.mem_done = 0;
        mid();
        chk("stray no issue", 32'(bus.mem_en), 32'h0);
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
